// File: rtl/rv32i_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_cache_dm
//  Description : Parametrised direct-mapped, write-back, write-allocate cache
//                between a word-wide RV32I memory port and a line-wide
//                physical memory. Byte-masked writes, dirty eviction and
//                saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_cache_dm #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    // core side
    input  logic [31:0]                    mem_address,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic [3:0]                     mem_wmask,
    input  logic [31:0]                    mem_wdata,
    output logic [31:0]                    mem_rdata,
    output logic                           mem_resp,
    // physical memory side
    output logic [31:0]                    pmem_address,
    output logic                           pmem_read,
    output logic                           pmem_write,
    output logic [8*(2**S_OFFSET)-1:0]     pmem_wdata,
    input  logic [8*(2**S_OFFSET)-1:0]     pmem_rdata,
    input  logic                           pmem_resp,
    // statistics
    output logic [31:0]                    hit_count,
    output logic [31:0]                    miss_count
);

    localparam int unsigned LINE   = 8 * (2 ** S_OFFSET);
    localparam int unsigned TAG    = 32 - S_INDEX - S_OFFSET;
    localparam int unsigned SETS   = 2 ** S_INDEX;
    localparam int unsigned WSEL_W = (S_OFFSET > 2) ? (S_OFFSET - 2) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2
    } state_t;

    state_t              r_state;
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;
    logic [TAG-1:0]      r_tag  [SETS];
    logic [LINE-1:0]     r_data [SETS];
    logic [TAG-1:0]      r_miss_tag;
    logic [S_INDEX-1:0]  r_miss_idx;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic                w_req;
    logic [TAG-1:0]      w_tag;
    logic [S_INDEX-1:0]  w_idx;
    logic [WSEL_W-1:0]   w_word;
    logic                w_hit;
    logic                w_wr_hit;
    logic [LINE-1:0]     w_line;
    logic [31:0]         w_sel_word;
    logic [LINE-1:0]     w_merged;
    logic                w_unused_addr;

    // Address decomposition; the byte-within-word bits carry no meaning here
    assign w_req         = mem_read | mem_write;
    assign w_tag         = mem_address[31 -: TAG];
    assign w_idx         = mem_address[S_OFFSET+S_INDEX-1 : S_OFFSET];
    assign w_unused_addr = ^mem_address[1:0];

    // A one-word line has no word-select field at all
    generate
        if (S_OFFSET > 2) begin : g_multi_word
            assign w_word = mem_address[S_OFFSET-1:2];
        end else begin : g_single_word
            assign w_word = '0;
        end
    endgenerate

    assign w_line     = r_data[w_idx];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_sel_word = w_line[32*int'(w_word) +: 32];

    // Hits complete combinationally in the request cycle
    assign mem_resp   = (r_state == ST_IDLE) && w_req && w_hit;
    assign mem_rdata  = mem_resp ? w_sel_word : 32'd0;
    assign w_wr_hit   = mem_resp && mem_write;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Byte-masked merge of the write word into the resident line
    always_comb begin
        w_merged = w_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) begin
                w_merged[32*int'(w_word) + 8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    // Tag/data storage: fills install the latched miss line, write hits merge
    always_ff @(posedge clk) begin
        if (r_state == ST_FETCH && pmem_resp) begin
            r_data[r_miss_idx] <= pmem_rdata;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= w_merged;
        end
    end

    // Controller: miss handling, memory handshakes, valid/dirty and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= 32'd0;
            pmem_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (r_hit_count != 32'hFFFF_FFFF) begin
                                r_hit_count <= r_hit_count + 32'd1;
                            end
                            if (mem_write) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            if (r_miss_count != 32'hFFFF_FFFF) begin
                                r_miss_count <= r_miss_count + 32'd1;
                            end
                            // Latch the miss line so a withdrawn request still installs it
                            r_miss_tag <= w_tag;
                            r_miss_idx <= w_idx;
                            if (r_valid[w_idx] && r_dirty[w_idx]) begin
                                r_state      <= ST_WRITEBACK;
                                pmem_write   <= 1'b1;
                                pmem_address <= {r_tag[w_idx], w_idx, {S_OFFSET{1'b0}}};
                                pmem_wdata   <= w_line;
                            end else begin
                                r_state      <= ST_FETCH;
                                pmem_read    <= 1'b1;
                                pmem_address <= {w_tag, w_idx, {S_OFFSET{1'b0}}};
                            end
                        end
                    end
                end

                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_state      <= ST_FETCH;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {r_miss_tag, r_miss_idx, {S_OFFSET{1'b0}}};
                    end
                end

                ST_FETCH: begin
                    if (pmem_resp) begin
                        r_state             <= ST_IDLE;
                        pmem_read           <= 1'b0;
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_cache_dm
//  Description : Self-checking bench for rv32i_cache_dm. A flat golden memory
//                plus a residency map give the expected data, traffic and
//                counter values; a second instance covers a wider geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_cache_dm;

    localparam int NW = 8;     // words per line, default geometry
    localparam int LW = 256;

    logic           clk = 1'b0;
    logic           rst;
    always #5 clk = ~clk;

    // default-geometry DUT
    logic [31:0]    mem_address, mem_wdata, mem_rdata, pmem_address;
    logic           mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [3:0]     mem_wmask;
    logic [LW-1:0]  pmem_wdata, pmem_rdata;
    logic [31:0]    hit_count, miss_count;

    // wide-geometry DUT (16 sets, 64-byte lines)
    logic [31:0]    b_address, b_wdata, b_rdata, b_paddr;
    logic           b_read, b_write, b_resp, b_pread, b_pwrite, b_presp;
    logic [3:0]     b_wmask;
    logic [511:0]   b_pwdata, b_prdata;
    logic [31:0]    b_hit, b_miss;

    rv32i_cache_dm #(.S_INDEX(3), .S_OFFSET(5)) u_a (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    rv32i_cache_dm #(.S_INDEX(4), .S_OFFSET(6)) u_b (
        .clk(clk), .rst(rst),
        .mem_address(b_address), .mem_read(b_read), .mem_write(b_write),
        .mem_wmask(b_wmask), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_resp(b_resp), .pmem_address(b_paddr), .pmem_read(b_pread),
        .pmem_write(b_pwrite), .pmem_wdata(b_pwdata), .pmem_rdata(b_prdata),
        .pmem_resp(b_presp), .hit_count(b_hit), .miss_count(b_miss)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] bmem [int unsigned];   // what physical memory holds
    logic [31:0] gold [int unsigned];   // what the core should observe
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [23:0] m_tag   [8];
    logic [31:0] m_hit, m_miss;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rd_b(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_g(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : init_word(a);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = '0;
        end
        m_hit  = 0;
        m_miss = 0;
        gold   = bmem;   // unwritten-back dirty data is lost on reset
    endtask

    // One core access on the default DUT, acting as physical memory meanwhile
    task automatic access(input bit wr, input bit rd_too, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wd,
                          output logic [31:0] rdat);
        logic [2:0]  idx;
        logic [23:0] tg;
        logic [31:0] la, wa, va, g;
        bit          hit, dirty, done, in_wb, in_fill;
        int          cyc, lat, fill_cyc, wb_cyc;
        idx = addr[7:5];
        tg  = addr[31:8];
        la  = addr & ~32'h1F;
        wa  = addr & ~32'h3;
        va  = {m_tag[idx], idx, 5'b0};
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        dirty = !hit && m_valid[idx] && m_dirty[idx];
        done = 0; in_wb = 0; in_fill = 0;
        cyc = 0; lat = -1; fill_cyc = -1; wb_cyc = -1;
        rdat = 32'd0;

        @(negedge clk);
        mem_address = addr;
        mem_read    = wr ? rd_too : 1'b1;
        mem_write   = wr;
        mem_wmask   = mask;
        mem_wdata   = wd;
        while (!done && cyc < 100) begin
            #1;
            if (mem_resp) begin
                chk("resp_latency", 32'(cyc), hit ? 32'd0 : 32'(fill_cyc + 1));
                if (!wr) chk("rdata", mem_rdata, rd_g(wa));
                rdat = mem_rdata;
                done = 1;
            end else begin
                chk("rdata_zero", mem_rdata, 32'd0);
                if (pmem_write) begin
                    if (!in_wb) begin
                        in_wb = 1;
                        chk("wb_expected", 32'(dirty), 32'd1);
                        chk("wb_start", 32'(cyc), 32'd1);
                        chk("wb_addr", pmem_address, va);
                        lat = $urandom_range(0, 3);
                    end
                    if (lat == 0) begin
                        pmem_resp = 1'b1;
                        for (int w = 0; w < NW; w++) begin
                            chk("wb_data", pmem_wdata[w*32 +: 32], rd_g(va + 32'(4*w)));
                            bmem[va + 32'(4*w)] = pmem_wdata[w*32 +: 32];
                        end
                        wb_cyc = cyc;
                    end
                    lat--;
                end else if (pmem_read) begin
                    if (!in_fill) begin
                        in_fill = 1;
                        chk("fill_start", 32'(cyc), dirty ? 32'(wb_cyc + 1) : 32'd1);
                        chk("fill_addr", pmem_address, la);
                        lat = $urandom_range(0, 3);
                    end
                    if (lat == 0) begin
                        pmem_resp = 1'b1;
                        for (int w = 0; w < NW; w++)
                            pmem_rdata[w*32 +: 32] = rd_b(la + 32'(4*w));
                        fill_cyc = cyc;
                    end
                    lat--;
                end
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            cyc++;
        end
        chk("access_timeout", 32'(done), 32'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;

        if (!hit) begin
            m_miss       = sat(m_miss);
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 0;
        end
        m_hit = sat(m_hit);
        if (wr) begin
            g = rd_g(wa);
            for (int b = 0; b < 4; b++)
                if (mask[b]) g[b*8 +: 8] = wd[b*8 +: 8];
            gold[wa]     = g;
            m_dirty[idx] = 1;
        end
        #1;
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, a;
        bit          seen;

        rst = 1'b1;
        mem_address = 0; mem_read = 0; mem_write = 0; mem_wmask = 0; mem_wdata = 0;
        pmem_resp = 0; pmem_rdata = '0;
        b_address = 0; b_read = 0; b_write = 0; b_wmask = 0; b_wdata = 0;
        b_presp = 0; b_prdata = '0;
        model_reset();

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk("rst_pmem_address", pmem_address, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- directed: fill, masked write, dirty eviction ----
        bmem[32'h44] = 32'hDEAD_BEEF;
        gold[32'h44] = 32'hDEAD_BEEF;
        access(0, 0, 32'h44, 4'h0, 32'h0, r);
        chk("t1_rdata", r, 32'hDEAD_BEEF);
        chk("t1_miss", miss_count, 32'd1);
        chk("t1_hit", hit_count, 32'd1);
        access(1, 0, 32'h44, 4'b0011, 32'h1234_5678, r);
        access(0, 0, 32'h44, 4'h0, 32'h0, r);
        chk("t2_rdata", r, 32'hDEAD_5678);
        access(0, 0, 32'h144, 4'h0, 32'h0, r);
        chk("t3_wb_word1", rd_b(32'h44), 32'hDEAD_5678);
        chk("t3_miss", miss_count, 32'd2);

        // ---- reset in the middle of a fill ----
        @(negedge clk);
        mem_address = 32'h1000;
        mem_read    = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (pmem_read) seen = 1;
            else @(negedge clk);
        end
        chk("rst_fetch_started", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_fetch_pread", 32'(pmem_read), 32'd0);
        chk("rst_fetch_pwrite", 32'(pmem_write), 32'd0);
        chk("rst_fetch_hit", hit_count, 32'd0);
        chk("rst_fetch_miss", miss_count, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        access(0, 0, 32'h140, 4'h0, 32'h0, r);
        chk("post_rst_miss", miss_count, 32'd1);

        // ---- request withdrawn while the fill is outstanding ----
        @(negedge clk);
        mem_address = 32'h2A0;
        mem_read    = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (pmem_read) seen = 1;
            else @(negedge clk);
        end
        chk("wd_fill_started", 32'(pmem_read), 32'd1);
        @(negedge clk);
        mem_read = 1'b0;
        for (int w = 0; w < NW; w++) pmem_rdata[w*32 +: 32] = rd_b(32'h2A0 + 32'(4*w));
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        m_miss = sat(m_miss);
        m_valid[5] = 1; m_tag[5] = 24'h2; m_dirty[5] = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wd_no_resp", 32'(mem_resp), 32'd0);
            chk("wd_hit_count", hit_count, m_hit);
            @(negedge clk);
        end
        access(0, 0, 32'h2A4, 4'h0, 32'h0, r);   // installed line must hit

        // ---- randomized traffic over a small conflict-heavy footprint ----
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                // stray pmem_resp while idle must be ignored
                @(negedge clk);
                for (int w = 0; w < NW; w++) pmem_rdata[w*32 +: 32] = $urandom;
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
            end
            a = 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 7) << 5)
              | 32'($urandom_range(0, 7) << 2);
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   4'($urandom_range(0, 15)), $urandom, r);
        end

        // ---- counter saturation ----
        @(negedge clk);
        force u_a.r_hit_count  = 32'hFFFF_FFFE;
        force u_a.r_miss_count = 32'hFFFF_FFFE;
        #1;
        release u_a.r_hit_count;
        release u_a.r_miss_count;
        m_hit  = 32'hFFFF_FFFE;
        m_miss = 32'hFFFF_FFFE;
        access(0, 0, 32'h140, 4'h0, 32'h0, r);
        access(0, 0, 32'h144, 4'h0, 32'h0, r);
        access(0, 0, 32'h148, 4'h0, 32'h0, r);
        chk("hit_saturated", hit_count, 32'hFFFF_FFFF);
        access(0, 0, 32'h5000, 4'h0, 32'h0, r);
        access(0, 0, 32'h6000, 4'h0, 32'h0, r);
        chk("miss_saturated", miss_count, 32'hFFFF_FFFF);

        // ---- wide geometry: 16 sets, 64-byte lines ----
        @(negedge clk);
        b_address = 32'h3C4;
        b_read    = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (b_pread) seen = 1;
            else @(negedge clk);
        end
        chk("b_pread", 32'(b_pread), 32'd1);
        chk("b_paddr", b_paddr, 32'h3C0);
        for (int w = 0; w < 16; w++) b_prdata[w*32 +: 32] = 32'h1000_0000 + 32'(w);
        b_presp = 1'b1;
        @(negedge clk);
        b_presp = 1'b0;
        #1;
        chk("b_resp", 32'(b_resp), 32'd1);
        chk("b_rdata_w1", b_rdata, 32'h1000_0001);
        @(negedge clk);
        b_address = 32'h3F8;
        #1;
        chk("b_hit_resp", 32'(b_resp), 32'd1);
        chk("b_rdata_w14", b_rdata, 32'h1000_000E);
        @(negedge clk);
        b_read = 1'b0;
        #1;
        chk("b_hit_count", b_hit, 32'd2);
        chk("b_miss_count", b_miss, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
